// File: rtl/xtea_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : xtea_stream_ctrl_if
// Description : Bus bundle for the XTEA stream controller: 32-bit input word
//               stream, 32-bit output word stream and the 128-bit core link.
//               The slave modport is the controller's view; the master modport
//               is the surrounding system (word source, word sink, xtea core).
// Revision    : 1.0 - initial release
// ============================================================================
interface xtea_stream_ctrl_if;
  // upstream word stream
  logic         enc_dec_in;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  // downstream word stream
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  // xtea core link
  logic         core_start;
  logic         core_enc_dec;
  logic [127:0] core_data_in;
  logic         core_ready;
  logic         core_busy;
  logic [127:0] core_data_out;

  modport master (
    output enc_dec_in, s_valid, s_data, m_ready,
    output core_ready, core_busy, core_data_out,
    input  s_ready, m_valid, m_data,
    input  core_start, core_enc_dec, core_data_in
  );

  modport slave (
    input  enc_dec_in, s_valid, s_data, m_ready,
    input  core_ready, core_busy, core_data_out,
    output s_ready, m_valid, m_data,
    output core_start, core_enc_dec, core_data_in
  );
endinterface
`default_nettype wire

// File: rtl/xtea_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : xtea_stream_ctrl
// Description : Packs four 32-bit input words into a 128-bit block, starts the
//               xtea core, waits (bounded) for its result and streams the
//               result back out as four 32-bit words. One block in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module xtea_stream_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,      // synchronous, active low
  xtea_stream_ctrl_if.slave bus,
  output logic             err_timeout,
  output logic [CNT_W-1:0] blk_count
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // timer only needs to hold 0..TIMEOUT-1; the last value triggers the abort
  localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [1:0]       state_q,   state_d;
  logic [1:0]       idx_q,     idx_d;     // word slot, shared by load and drain
  logic [127:0]     blk_q,     blk_d;     // block presented to the core
  logic             mode_q,    mode_d;
  logic [127:0]     obuf_q,    obuf_d;    // captured core result
  logic [TMR_W-1:0] timer_q,   timer_d;
  logic             err_q,     err_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             s_ready_q, s_ready_d;

  // word k lives at bits [127-32k -: 32]; 3-k is simply ~k on two bits
  logic [6:0] slot_lsb;
  assign slot_lsb = {~idx_q, 5'b00000};

  // busy is informational only; control relies on the ready pulse
  logic unused_busy;
  assign unused_busy = bus.core_busy;

  assign bus.s_ready      = s_ready_q;
  assign bus.m_valid      = (state_q == S_DRAIN);
  assign bus.m_data       = obuf_q[slot_lsb +: 32];
  assign bus.core_start   = (state_q == S_START);
  assign bus.core_enc_dec = mode_q;
  assign bus.core_data_in = blk_q;
  assign err_timeout      = err_q;
  assign blk_count        = cnt_q;

  // next-state logic for the load / start / wait / drain sequence
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    blk_d   = blk_q;
    mode_d  = mode_q;
    obuf_d  = obuf_q;
    timer_d = timer_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOAD: begin
        if (bus.s_valid && s_ready_q) begin
          blk_d[slot_lsb +: 32] = bus.s_data;
          if (idx_q == 2'd0) begin
            mode_d = bus.enc_dec_in;
          end
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = S_START;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // a result arriving on the last allowed cycle still counts
        if (bus.core_ready) begin
          obuf_d  = bus.core_data_out;
          idx_d   = 2'd0;
          state_d = S_DRAIN;
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          idx_d   = 2'd0;
          state_d = S_LOAD;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (bus.m_ready) begin
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            cnt_d   = cnt_q + 1'b1;
            state_d = S_LOAD;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_LOAD;
        idx_d   = 2'd0;
      end
    endcase
    // registered so that it stays low for the cycle following a reset
    s_ready_d = (state_d == S_LOAD);
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_LOAD;
      idx_q     <= 2'd0;
      blk_q     <= '0;
      mode_q    <= 1'b1;
      obuf_q    <= '0;
      timer_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      blk_q     <= blk_d;
      mode_q    <= mode_d;
      obuf_q    <= obuf_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xtea_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_xtea_stream_ctrl
// Description : Self-checking bench for xtea_stream_ctrl with a behavioural
//               xtea core model and an output-word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xtea_stream_ctrl;

  localparam int          TMO      = 16;
  localparam int          CORE_LAT = 8;
  localparam logic [127:0] PT = 128'h4D932AB3CE76E4F22555F334089975E9;
  localparam logic [127:0] B2 = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] B3 = 128'h00000000FFFFFFFFA5A5A5A55A5A5A5A;
  localparam logic [127:0] B4 = 128'h1111111122222222333333334444444;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        err_timeout;
  logic [15:0] blk_count;

  xtea_stream_ctrl_if bus ();

  xtea_stream_ctrl #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .err_timeout (err_timeout),
    .blk_count   (blk_count)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int start_seen = 0;
  logic [31:0] exp_q[$];

  // ---------------- xtea reference (two 64-bit blocks, 32 cycles) ----------
  logic [127:0] key = 128'hDEADBEEF89ABCDEF01234567DEADBEEF;

  function automatic logic [63:0] xtea64(input logic [63:0] v, input bit enc);
    logic [31:0] v0, v1, sum;
    logic [31:0] k [4];
    k[0] = key[127:96]; k[1] = key[95:64]; k[2] = key[63:32]; k[3] = key[31:0];
    v0 = v[63:32]; v1 = v[31:0];
    if (enc) begin
      sum = 32'd0;
      for (int r = 0; r < 32; r++) begin
        v0  += (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]);
        sum += 32'h9E3779B9;
        v1  += (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]);
      end
    end else begin
      sum = 32'hC6EF3720;
      for (int r = 0; r < 32; r++) begin
        v1  -= (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]);
        sum -= 32'h9E3779B9;
        v0  -= (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]);
      end
    end
    return {v0, v1};
  endfunction

  function automatic logic [127:0] xtea_blk(input logic [127:0] b, input bit enc);
    return {xtea64(b[127:64], enc), xtea64(b[63:0], enc)};
  endfunction

  // ---------------- core model ----------------
  bit           core_on = 1'b1;
  logic         auto_rdy = 1'b0;
  logic         tb_rdy = 1'b0;
  logic [127:0] core_res = '0;
  int           core_cnt = 0;

  assign bus.core_ready    = auto_rdy | tb_rdy;
  assign bus.core_data_out = core_res;
  assign bus.core_busy     = (core_cnt != 0);

  always @(negedge clock) begin
    auto_rdy = 1'b0;
    if (bus.core_start === 1'b1) begin
      core_res = xtea_blk(bus.core_data_in, bus.core_enc_dec);
      core_cnt = CORE_LAT;
    end else if (core_cnt != 0) begin
      core_cnt--;
      if (core_cnt == 0 && core_on) auto_rdy = 1'b1;
    end
  end

  // ---------------- output scoreboard ----------------
  always begin
    @(negedge clock);
    #1;
    if (bus.core_start === 1'b1) start_seen++;
    if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL drain_word: got %h, required no output word", bus.m_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.m_data !== e) begin
          n_err++;
          $display("FAIL drain_word: got %h, required %h", bus.m_data, e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_block(input logic [127:0] b);
    for (int w = 0; w < 4; w++) exp_q.push_back(b[(3-w)*32 +: 32]);
  endtask

  // called at a negedge; returns at the negedge of the START cycle
  task automatic send_block(input logic [127:0] blk, input bit ed, input bit toggle);
    int t;
    for (int w = 0; w < 4; w++) begin
      bus.s_valid    = 1'b1;
      bus.s_data     = blk[(3-w)*32 +: 32];
      bus.enc_dec_in = (toggle && (w % 2 == 1)) ? ~ed : ed;
      t = 0;
      while (bus.s_ready !== 1'b1 && t < 200) begin
        @(negedge clock);
        t++;
      end
      if (t >= 200) begin
        n_vec++; n_err++;
        $display("FAIL load_accept: word %0d s_ready=%b, required 1", w, bus.s_ready);
      end
      @(negedge clock);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.m_valid === 1'b1) && t < 400) begin
      @(negedge clock);
      t++;
    end
    n_vec++;
    if (t >= 400) begin
      n_err++;
      $display("FAIL drain_done: %0d words outstanding, required 0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_vec++;
    if ({bus.s_ready, bus.m_valid, bus.core_start, bus.core_enc_dec, err_timeout} !== 5'b00010) begin
      n_err++;
      $display("FAIL reset_flags: got s_ready/m_valid/start/enc_dec/err=%b%b%b%b%b, required 00010",
               bus.s_ready, bus.m_valid, bus.core_start, bus.core_enc_dec, err_timeout);
    end
    n_vec++;
    if (bus.core_data_in !== 128'd0 || bus.m_data !== 32'd0 || blk_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_data: got data_in=%h m_data=%h blk=%0d, required zeros",
               bus.core_data_in, bus.m_data, blk_count);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_vec++;
    if (bus.s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b, required 1", bus.s_ready);
    end
  endtask

  task automatic test_load();
    int s0;
    s0 = start_seen;
    push_block(xtea_blk(PT, 1'b1));
    send_block(PT, 1'b1, 1'b0);
    n_vec++;
    if (bus.core_start !== 1'b1) begin
      n_err++;
      $display("FAIL load_start: got %b, required 1", bus.core_start);
    end
    n_vec++;
    if (bus.core_data_in !== PT) begin
      n_err++;
      $display("FAIL load_block: got %h, required %h", bus.core_data_in, PT);
    end
    n_vec++;
    if (bus.core_enc_dec !== 1'b1) begin
      n_err++;
      $display("FAIL load_mode: got %b, required 1", bus.core_enc_dec);
    end
    @(negedge clock);
    n_vec++;
    if (bus.core_start !== 1'b0) begin
      n_err++;
      $display("FAIL load_start_width: got %b, required 0", bus.core_start);
    end
    wait_drain();
    n_vec++;
    if (start_seen - s0 != 1) begin
      n_err++;
      $display("FAIL load_start_count: got %0d, required 1", start_seen - s0);
    end
    n_vec++;
    if (blk_count !== 16'd1) begin
      n_err++;
      $display("FAIL load_blk_count: got %0d, required 1", blk_count);
    end
  endtask

  task automatic test_round_trip();
    push_block(PT);
    send_block(xtea_blk(PT, 1'b1), 1'b0, 1'b0);
    wait_drain();
    n_vec++;
    if (blk_count !== 16'd2) begin
      n_err++;
      $display("FAIL round_trip_blk_count: got %0d, required 2", blk_count);
    end
  endtask

  task automatic test_backpressure();
    int t = 0;
    logic [31:0] hold;
    bit bad = 1'b0;
    push_block(xtea_blk(B2, 1'b1));
    send_block(B2, 1'b1, 1'b0);
    while (bus.m_valid !== 1'b1 && t < 100) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);           // word 0 taken, word 1 now presented
    bus.m_ready = 1'b0;
    hold = bus.m_data;
    repeat (3) begin
      @(negedge clock);
      if (bus.m_valid !== 1'b1 || bus.m_data !== hold || bus.s_ready !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL stall_hold: got m_valid=%b m_data=%h s_ready=%b, required 1 %h 0",
               bus.m_valid, bus.m_data, bus.s_ready, hold);
    end
    bus.m_ready = 1'b1;
    bad = 1'b0;
    t = 0;
    while (bus.m_valid === 1'b1 && t < 20) begin
      if (bus.s_ready !== 1'b0) bad = 1'b1;
      @(negedge clock);
      t++;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL stall_s_ready: got 1 during drain, required 0");
    end
    wait_drain();
    n_vec++;
    if (blk_count !== 16'd3) begin
      n_err++;
      $display("FAIL stall_blk_count: got %0d, required 3", blk_count);
    end
  endtask

  task automatic test_mode_latch();
    push_block(xtea_blk(B3, 1'b0));
    send_block(B3, 1'b0, 1'b1);
    n_vec++;
    if (bus.core_enc_dec !== 1'b0) begin
      n_err++;
      $display("FAIL mode_start: got %b, required 0", bus.core_enc_dec);
    end
    bus.enc_dec_in = 1'b1;
    repeat (2) @(negedge clock);
    n_vec++;
    if (bus.core_enc_dec !== 1'b0) begin
      n_err++;
      $display("FAIL mode_wait: got %b, required 0", bus.core_enc_dec);
    end
    wait_drain();
    n_vec++;
    if (blk_count !== 16'd4) begin
      n_err++;
      $display("FAIL mode_blk_count: got %0d, required 4", blk_count);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] c0;
    bit early = 1'b0;
    c0 = blk_count;
    core_on = 1'b0;
    send_block(B4, 1'b1, 1'b0);   // START cycle
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clock);
      if (err_timeout !== 1'b0) early = 1'b1;
    end
    n_vec++;
    if (early) begin
      n_err++;
      $display("FAIL timeout_early: got err_timeout=1 within %0d cycles, required 0", TMO);
    end
    @(negedge clock);
    n_vec++;
    if (err_timeout !== 1'b1 || bus.s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_abort: got err=%b s_ready=%b, required 1 1", err_timeout, bus.s_ready);
    end
    n_vec++;
    if (blk_count !== c0) begin
      n_err++;
      $display("FAIL timeout_blk_count: got %0d, required %0d", blk_count, c0);
    end
    core_on = 1'b1;
    push_block(xtea_blk(B2, 1'b0));
    send_block(B2, 1'b0, 1'b0);
    wait_drain();
    n_vec++;
    if (err_timeout !== 1'b1 || blk_count !== c0 + 16'd1) begin
      n_err++;
      $display("FAIL timeout_after: got err=%b blk=%0d, required 1 %0d", err_timeout, blk_count, c0 + 16'd1);
    end
  endtask

  task automatic test_reset_mid_op();
    bit bad = 1'b0;
    core_on = 1'b0;
    send_block(B3, 1'b0, 1'b0);
    repeat (3) @(negedge clock);   // in WAIT
    reset = 1'b0;
    @(negedge clock);
    reset  = 1'b1;
    tb_rdy = 1'b1;
    n_vec++;
    if ({bus.s_ready, bus.m_valid, bus.core_start, bus.core_enc_dec, err_timeout} !== 5'b00010
        || bus.core_data_in !== 128'd0 || blk_count !== 16'd0 || bus.m_data !== 32'd0) begin
      n_err++;
      $display("FAIL midreset_state: got flags=%b%b%b%b%b data_in=%h blk=%0d m_data=%h, required 00010 0 0 0",
               bus.s_ready, bus.m_valid, bus.core_start, bus.core_enc_dec, err_timeout,
               bus.core_data_in, blk_count, bus.m_data);
    end
    @(negedge clock);
    tb_rdy = 1'b0;
    repeat (12) begin
      if (bus.m_valid !== 1'b0) bad = 1'b1;
      @(negedge clock);
    end
    n_vec++;
    if (bad || bus.s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_ignore: got m_valid high=%b s_ready=%b, required 0 1", bad, bus.s_ready);
    end
    core_on = 1'b1;
    push_block(xtea_blk(PT, 1'b1));
    send_block(PT, 1'b1, 1'b0);
    wait_drain();
    n_vec++;
    if (blk_count !== 16'd1) begin
      n_err++;
      $display("FAIL midreset_fresh: got blk=%0d, required 1", blk_count);
    end
  endtask

  initial begin
    bus.s_valid    = 1'b0;
    bus.s_data     = 32'd0;
    bus.enc_dec_in = 1'b1;
    bus.m_ready    = 1'b1;
    @(negedge clock);
    test_reset();
    test_load();
    test_round_trip();
    test_backpressure();
    test_mode_latch();
    test_timeout();
    test_reset_mid_op();
    repeat (3) @(negedge clock);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got %0d words left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xtea_stream_ctrl.md
Name: xtea_stream_ctrl

Overview:
- Stream front/back end for the 128-bit xtea core.
- Packs four 32-bit input words into one 128-bit block and pulses the core start.
- Waits for the core's ready, captures the result, and unpacks it as four 32-bit output words.
- Sits between the system word bus and the xtea core. The key is wired to the core directly from the top level.

Parameters:
- TIMEOUT, 256: max cycles to wait for core_ready after core_start before aborting the block.
- CNT_W, 16: width of blk_count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- enc_dec_in  in  1  mode for the next block (1 = encrypt, 0 = decrypt), sampled on word 0 accept.
- s_valid  in  1  input word valid.
- s_ready  out  1  controller can accept an input word.
- s_data  in  32  input word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts output word.
- m_data  out  32  output word.
- core_start  out  1  one-cycle start pulse to the core.
- core_enc_dec  out  1  mode to the core.
- core_data_in  out  128  block to the core.
- core_ready  in  1  core result valid (pulse).
- core_busy  in  1  core running (status only, not used for control).
- core_data_out  in  128  core result.
- err_timeout  out  1  sticky: a block was aborted by timeout.
- blk_count  out  CNT_W  count of blocks fully drained.

Behaviour:
- Reset (reset==0 at a rising edge): state=LOAD, word index 0, all buffers 0.
  - s_ready=0 during reset cycle, then 1.
  - m_valid=0, m_data=0, core_start=0, core_enc_dec=1, core_data_in=0, err_timeout=0, blk_count=0.
  - Reset mid-operation aborts everything; a pending core result is ignored.
- States: LOAD, START, WAIT, DRAIN.
- LOAD:
  - s_ready=1. A word is accepted on s_valid && s_ready.
  - Word k (k = 0..3) is written to core_data_in[127-32k -: 32]; word 0 goes to the MSBs.
  - enc_dec_in is latched into core_enc_dec on word 0 accept only. Later changes are ignored for that block.
  - After the word 3 accept, go to START. s_ready=0 in all other states.
- START:
  - core_start=1 for exactly one cycle, then WAIT with the timer cleared.
  - Latency: word 3 accepted at edge T, so core_start is high in the cycle after T.
- WAIT:
  - core_data_in and core_enc_dec are held stable until WAIT exits.
  - The timer increments each cycle.
  - If core_ready==1, capture core_data_out into the output buffer and go to DRAIN; m_valid=1 from the next cycle.
  - If the timer reaches TIMEOUT with no core_ready: set err_timeout, drop the block, go to LOAD with index 0. blk_count does not change.
  - If core_ready and timeout occur in the same cycle, core_ready wins.
- DRAIN:
  - m_valid=1 and m_data = output word k (word 0 = bits 127:96).
  - On m_valid && m_ready, advance k.
  - m_data must not change while m_valid && !m_ready.
  - After the word 3 handshake: m_valid=0, blk_count+1 (wraps modulo 2^CNT_W), go to LOAD.
- core_ready outside WAIT is ignored.
- err_timeout clears only on reset.
- At most one block in flight; no overlap between drain and the next load.
- Throughput with no stalls: 4 load cycles + 1 start + core latency + 4 drain cycles.

Test Plan:
- Load path:
  - Stimulus: words 4D932AB3, CE76E4F2, 2555F334, 089975E9 with enc_dec_in=1.
  - Required: core_data_in = 128'h4D932AB3CE76E4F22555F334089975E9, core_enc_dec=1, and exactly one core_start cycle, in the cycle after the word 3 accept.
- Round trip with the real xtea core, key DEADBEEF89ABCDEF01234567DEADBEEF:
  - Encrypt the block above, then feed the 4 output words back with enc_dec_in=0.
  - Required: the second drain returns 4D932AB3, CE76E4F2, 2555F334, 089975E9 in order; blk_count=2.
- Backpressure:
  - Stimulus: hold m_ready=0 for 3 cycles during word 1 of drain.
  - Required: m_valid stays 1, m_data is held constant, no word is skipped or duplicated, and s_ready stays 0 until drain completes.
- Timeout:
  - Stimulus: TIMEOUT=16, core model never asserts core_ready.
  - Required: err_timeout=1 exactly 16 cycles after core_start, s_ready=1 the next cycle, blk_count unchanged, and a subsequent normal block completes with err_timeout still 1.
- Mode latch:
  - Stimulus: enc_dec_in=0 at word 0, then toggle it every cycle during words 1-3.
  - Required: core_enc_dec=0 for the whole block.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle in WAIT, then pulse core_ready.
  - Required: all outputs at reset values, core_ready ignored, m_valid stays 0, and a fresh 4-word load works normally.
